// File: rtl/cim_pkg.sv
// Shared types and defaults for the CIM macro datapath.
package cim_pkg;
  localparam int ROWS_DEF   = 64;
  localparam int ABITS_DEF  = 4;
  localparam int BIDX_W_DEF = $clog2(ABITS_DEF);

  typedef logic [ABITS_DEF-1:0]  act_t;
  typedef logic [BIDX_W_DEF-1:0] bidx_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/sparse_plane_pick.sv
// Finds the highest non-zero bit-plane strictly below cur.
module sparse_plane_pick #(
  parameter int ABITS  = 4,
  parameter int BIDX_W = $clog2(ABITS)
) (
  input  logic [ABITS-1:0]  plane_nz,
  input  logic [BIDX_W:0]   cur,
  output logic [BIDX_W-1:0] next_idx,
  output logic              none_below
);
  // Ascending scan, so the last hit is the highest qualifying index.
  always_comb begin
    next_idx   = '0;
    none_below = 1'b1;
    for (int k = 0; k < ABITS; k++) begin
      if (plane_nz[k] && (k < int'(cur))) begin
        next_idx   = BIDX_W'(k);
        none_below = 1'b0;
      end
    end
  end
endmodule

// File: rtl/sparse_bitplane_driver.sv
// Streams one activation vector to the CIM array as MSB-first bit-planes, skipping all-zero planes.
module sparse_bitplane_driver
  import cim_pkg::*;
#(
  parameter  int ROWS   = ROWS_DEF,
  parameter  int ABITS  = ABITS_DEF,
  localparam int BIDX_W = $clog2(ABITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*ABITS-1:0] in_act,
  output logic                  wl_valid,
  input  logic                  wl_ready,
  output logic [ROWS-1:0]       wl_vec,
  output logic [BIDX_W-1:0]     wl_bit,
  output logic                  wl_last,
  output logic                  busy
);
  state_e                  state_q, state_d;
  logic [ROWS*ABITS-1:0]   act_q, act_d;
  logic [ABITS-1:0]        nz_q, nz_d;
  logic [BIDX_W-1:0]       cur_q, cur_d;
  logic                    allz_q, allz_d;

  logic [ABITS-1:0]        load_nz;
  logic [BIDX_W-1:0]       load_idx, step_idx;
  logic                    load_none, step_none;
  logic                    streaming;

  always_comb begin
    load_nz = '0;
    for (int k = 0; k < ABITS; k++)
      for (int r = 0; r < ROWS; r++)
        load_nz[k] = load_nz[k] | in_act[r*ABITS + k];
  end

  // Searching below ABITS yields the top non-zero plane; none_below then means all-zero.
  sparse_plane_pick #(.ABITS(ABITS), .BIDX_W(BIDX_W)) u_pick_load (
    .plane_nz   (load_nz),
    .cur        ((BIDX_W+1)'(ABITS)),
    .next_idx   (load_idx),
    .none_below (load_none)
  );

  sparse_plane_pick #(.ABITS(ABITS), .BIDX_W(BIDX_W)) u_pick_step (
    .plane_nz   (nz_q),
    .cur        ({1'b0, cur_q}),
    .next_idx   (step_idx),
    .none_below (step_none)
  );

  assign streaming = (state_q == STREAM);
  assign in_ready  = !streaming;
  assign busy      = streaming;
  assign wl_valid  = streaming;
  assign wl_bit    = streaming ? cur_q : '0;
  assign wl_last   = streaming & (allz_q | step_none);

  always_comb begin
    wl_vec = '0;
    for (int r = 0; r < ROWS; r++)
      wl_vec[r] = streaming & act_q[r*ABITS + int'(cur_q)];
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    nz_d    = nz_q;
    cur_d   = cur_q;
    allz_d  = allz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STREAM;
          act_d   = in_act;
          nz_d    = load_nz;
          cur_d   = load_idx;
          allz_d  = load_none;
        end
      end
      STREAM: begin
        if (wl_ready) begin
          if (wl_last) state_d = IDLE;
          else         cur_d   = step_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      nz_q    <= '0;
      cur_q   <= '0;
      allz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      nz_q    <= nz_d;
      cur_q   <= cur_d;
      allz_q  <= allz_d;
    end
  end
endmodule

// File: tb/tb_sparse_bitplane_driver.sv
// Scoreboard bench for sparse_bitplane_driver: expected beats are queued at acceptance.
module tb_sparse_bitplane_driver;
  import cim_pkg::*;
  localparam int R = ROWS_DEF;
  localparam int A = ABITS_DEF;
  localparam int B = BIDX_W_DEF;

  typedef struct packed {
    logic [R-1:0] vec;
    logic [B-1:0] bidx;
    logic         last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [R*A-1:0] in_act;
  logic           wl_valid;
  logic           wl_ready;
  logic [R-1:0]   wl_vec;
  logic [B-1:0]   wl_bit;
  logic           wl_last;
  logic           busy;

  beat_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  sparse_bitplane_driver dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_act   (in_act),
    .wl_valid (wl_valid),
    .wl_ready (wl_ready),
    .wl_vec   (wl_vec),
    .wl_bit   (wl_bit),
    .wl_last  (wl_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [R*A-1:0] fill(input logic [A-1:0] v);
    logic [R*A-1:0] res;
    for (int r = 0; r < R; r++) res[r*A +: A] = v;
    return res;
  endfunction

  // Expected beat list: every non-zero plane MSB first, or one empty terminating beat.
  task automatic push_model(input logic [R*A-1:0] act);
    logic [R-1:0] pl [A];
    logic [A-1:0] nz;
    int lo;
    beat_t e;
    lo = -1;
    for (int k = 0; k < A; k++) begin
      for (int r = 0; r < R; r++) pl[k][r] = act[r*A + k];
      nz[k] = |pl[k];
    end
    for (int k = 0; k < A; k++) if (nz[k] && lo < 0) lo = k;
    if (nz == '0) begin
      e.vec = '0; e.bidx = '0; e.last = 1'b1;
      sb.push_back(e);
    end else begin
      for (int k = A-1; k >= 0; k--) begin
        if (nz[k]) begin
          e.vec = pl[k]; e.bidx = B'(k); e.last = (k == lo);
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic run_single(input string name, input logic [R*A-1:0] act,
                            input int stall_beat, input int stall_cycles);
    int n, beat;
    bit done;
    beat_t e;
    wl_ready = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick; n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept_wait: in_ready=%b required 1", name, in_ready);
    end
    push_model(act);
    in_act = act; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    beat = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (wl_valid !== 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL %s beat%0d_valid: wl_valid=%b required 1", name, beat, wl_valid);
        break;
      end
      if (beat == stall_beat && sb.size() > 0) begin
        e = sb[0];
        wl_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick;
          vectors++;
          if ({wl_valid, in_ready, wl_vec, wl_bit, wl_last} !== {1'b1, 1'b0, e.vec, e.bidx, e.last}) begin
            miscompares++;
            $display("FAIL %s stall%0d: got v=%b rdy=%b vec=%h bit=%0d last=%b required v=1 rdy=0 vec=%h bit=%0d last=%b",
                     name, s, wl_valid, in_ready, wl_vec, wl_bit, wl_last, e.vec, e.bidx, e.last);
          end
        end
        wl_ready = 1'b1;
      end
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL %s extra_beat: bit=%0d vec=%h required no beat", name, wl_bit, wl_vec);
      end else begin
        e = sb.pop_front();
        if ({in_ready, wl_vec, wl_bit, wl_last} !== {1'b0, e.vec, e.bidx, e.last}) begin
          miscompares++;
          $display("FAIL %s beat%0d: got rdy=%b vec=%h bit=%0d last=%b required rdy=0 vec=%h bit=%0d last=%b",
                   name, beat, in_ready, wl_vec, wl_bit, wl_last, e.vec, e.bidx, e.last);
        end
      end
      done = wl_last;
      tick;
      beat++;
      if (done) begin
        vectors++;
        if ({in_ready, busy, wl_valid, wl_vec} !== {3'b100, {R{1'b0}}}) begin
          miscompares++;
          $display("FAIL %s post_last: rdy=%b busy=%b v=%b vec=%h required 1 0 0 0",
                   name, in_ready, busy, wl_valid, wl_vec);
        end
      end
    end
    vectors++;
    if (!done || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s completion: done=%b pending=%0d required done=1 pending=0", name, done, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; wl_ready = 1'b0; in_act = '0;
    #12;
    vectors++;
    if ({in_ready, wl_valid, busy, wl_last, wl_bit, wl_vec} !== {4'b1000, {B{1'b0}}, {R{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_during: rdy=%b v=%b busy=%b last=%b bit=%0d vec=%h required 1 0 0 0 0 0",
               in_ready, wl_valid, busy, wl_last, wl_bit, wl_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    vectors++;
    if ({in_ready, wl_valid, busy, wl_last, wl_bit, wl_vec} !== {4'b1000, {B{1'b0}}, {R{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_after: rdy=%b v=%b busy=%b last=%b bit=%0d vec=%h required 1 0 0 0 0 0",
               in_ready, wl_valid, busy, wl_last, wl_bit, wl_vec);
    end
  endtask

  task automatic test_sparse;
    run_single("skip_plane2", fill(4'b1011), -1, 0);
  endtask

  task automatic test_all_zero;
    run_single("all_zero", fill(4'b0000), -1, 0);
  endtask

  task automatic test_corner_rows;
    logic [R*A-1:0] act;
    act = '0;
    act[0 +: A]       = 4'd8;
    act[(R-1)*A +: A] = 4'd1;
    run_single("corner_rows", act, -1, 0);
  endtask

  task automatic test_backpressure;
    run_single("backpressure", fill(4'b1111), 1, 5);
  endtask

  task automatic test_random;
    logic [R*A-1:0] act;
    for (int v = 0; v < 6; v++) begin
      act = '0;
      for (int r = 0; r < R; r++)
        if ($urandom_range(0, 7) == 0) act[r*A +: A] = A'($urandom_range(0, (1 << A) - 1));
      run_single("random", act, v % 3, v);
    end
  endtask

  task automatic test_back_to_back;
    logic [R*A-1:0] va, vb;
    int acc, lastc;
    bit fin, took;
    beat_t e;
    va = fill(4'b1011); vb = fill(4'b0100);
    acc = 0; lastc = -100; fin = 1'b0;
    wl_ready = 1'b1; in_act = va; in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      took = in_ready;
      if (in_ready) begin
        if (acc > 0) begin
          vectors++;
          if (cyc - lastc != 1) begin
            miscompares++;
            $display("FAIL b2b_gap: accept %0d cycles after last handshake required 1", cyc - lastc);
          end
        end
        push_model(in_act);
        acc++;
      end
      if (wl_valid) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_overlap: in_ready=%b during stream required 0", in_ready);
        end
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra: bit=%0d required no beat", wl_bit);
        end else begin
          e = sb.pop_front();
          if ({wl_vec, wl_bit, wl_last} !== {e.vec, e.bidx, e.last}) begin
            miscompares++;
            $display("FAIL b2b_beat: got vec=%h bit=%0d last=%b required vec=%h bit=%0d last=%b",
                     wl_vec, wl_bit, wl_last, e.vec, e.bidx, e.last);
          end
        end
        if (wl_last) begin
          lastc = cyc;
          if (acc == 4) fin = 1'b1;
        end
      end
      tick;
      if (took) in_act = (acc % 2 == 1) ? vb : va;
    end
    in_valid = 1'b0;
    vectors++;
    if (!fin || sb.size() != 0 || acc != 4) begin
      miscompares++;
      $display("FAIL b2b_completion: fin=%b accepted=%0d pending=%0d required 1 4 0", fin, acc, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_rst_mid_stream;
    int n;
    wl_ready = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick; n++; end
    in_act = fill(4'b1111); in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    vectors++;
    if ({wl_valid, wl_bit, wl_vec} !== {1'b1, B'(3), {R{1'b1}}}) begin
      miscompares++;
      $display("FAIL rst_beat1: v=%b bit=%0d vec=%h required 1 3 all-ones", wl_valid, wl_bit, wl_vec);
    end
    tick;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({wl_valid, busy, wl_last, in_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_async: v=%b busy=%b last=%b rdy=%b required 0 0 0 1", wl_valid, busy, wl_last, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    vectors++;
    if ({in_ready, wl_valid, wl_vec} !== {2'b10, {R{1'b0}}}) begin
      miscompares++;
      $display("FAIL rst_release: rdy=%b v=%b vec=%h required 1 0 0", in_ready, wl_valid, wl_vec);
    end
    run_single("rst_next", fill(4'b0010), -1, 0);
  endtask

  initial begin
    test_reset;
    test_sparse;
    test_all_zero;
    test_corner_rows;
    test_backpressure;
    test_random;
    test_back_to_back;
    test_rst_mid_stream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sparse_bitplane_driver.md
Name: sparse_bitplane_driver

Overview:
- Producer end of the macro's adder-tree datapath. Accepts one vector of ROWS unsigned ABITS-bit activations and streams it to the CIM array as bit-planes, MSB first.
- Each beat carries one ROWS-wide wordline vector; downstream 4-bit adder pairs then sum the per-row products of that plane.
- All-zero bit-planes are skipped (sparsity), saving array cycles. The bit index is sent with each beat so the downstream shift-accumulate weights it correctly.

Parameters:
- ROWS, 64, number of wordlines/rows (even; two rows per 4-bit adder).
- ABITS, 4, activation width in bits (= number of bit-planes).
- BIDX_W, $clog2(ABITS), width of the bit-index output (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  activation vector valid.
- in_ready  output  1  driver can accept a vector.
- in_act  input  ROWS*ABITS  activations; row r occupies bits [r*ABITS +: ABITS].
- wl_valid  output  1  wordline beat valid.
- wl_ready  input  1  macro accepts beat.
- wl_vec  output  ROWS  bit-plane: wl_vec[r] = bit wl_bit of row r's activation.
- wl_bit  output  BIDX_W  bit-plane index of current beat.
- wl_last  output  1  final beat of current vector.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, activation register cleared. Outputs during and after reset: wl_valid=0, wl_vec=0, wl_bit=0, wl_last=0, busy=0, in_ready=1.
- IDLE:
  - in_ready=1, wl_valid=0.
  - On in_valid&&in_ready at edge N: register in_act and compute plane_nz[k] = OR over rows of bit k. Go to STREAM with cur = highest k where plane_nz[k]=1.
  - If every plane is zero, cur=0 and the vector is flagged all-zero.
- STREAM:
  - in_ready=0, busy=1, wl_valid=1 from edge N+1. First beat is visible 1 cycle after acceptance.
  - wl_vec = plane cur, wl_bit = cur.
  - wl_last=1 when no plane_nz[j]=1 for j<cur, or when the vector is all-zero.
  - On wl_valid&&wl_ready:
    - if wl_last, go to IDLE; in_ready=1 the next cycle.
    - otherwise cur = highest j<cur with plane_nz[j]=1.
- All-zero vector: exactly one beat, wl_vec=0, wl_bit=0, wl_last=1. The downstream accumulator always sees a terminating beat.
- Beat count per vector = popcount(plane_nz), minimum 1. Consecutive accepted beats are back-to-back with no bubble while wl_ready=1.
- Backpressure: while wl_valid&&!wl_ready, wl_vec, wl_bit and wl_last hold stable. No beat is dropped or duplicated.
- in_valid during STREAM is ignored (in_ready=0). There is no overlap between vectors.
- If in_valid is high on the same edge the last beat is accepted, the new vector is not taken on that edge. It is taken on the following edge, so the minimum gap is 1 cycle.
- rst mid-STREAM: wl_valid drops immediately (asynchronous), the partial vector is discarded, and there is no wl_last.
- All outputs are registered or decoded from registered state only. There are no combinational paths from in_valid or wl_ready to any output.

Decomposition:
- Shared package cim_pkg holds:
  - ROWS and ABITS defaults;
  - the activation typedef (logic [ABITS-1:0]);
  - the bit-index typedef;
  - the state enum {IDLE, STREAM}.
- One sub-module, sparse_plane_pick: combinational. Given plane_nz[ABITS-1:0] and cur, it returns next_idx (highest set index below cur) and none_below.
  - The same block with cur=ABITS produces the first-plane index at load.

Test Plan:
- All 64 rows = 4'b1011, wl_ready=1:
  - exactly 3 beats (bit3, bit1, bit0), each wl_vec=all-ones;
  - wl_last only on bit0; plane 2 never emitted;
  - in_ready returns 1 one cycle after the last beat.
- All rows = 0: one beat with wl_vec=0, wl_bit=0, wl_last=1; then IDLE.
- Row0=4'd8, row63=4'd1, others 0:
  - beat1 wl_bit=3, wl_vec=64'h1;
  - beat2 wl_bit=0, wl_vec=64'h8000_0000_0000_0000, wl_last=1.
- Vector 4'b1111 on all rows with wl_ready held low for 5 cycles on beat 2:
  - wl_bit=2 and wl_vec stay stable all 5 cycles;
  - 4 beats total; in_ready stays 0.
- in_valid held high continuously with alternating vectors:
  - no vector is accepted during STREAM;
  - each new acceptance occurs exactly 1 cycle after the prior wl_last handshake.
- rst pulsed mid-STREAM (after beat 1 of 4'b1111 on all rows):
  - wl_valid=0 in the same cycle, busy=0;
  - after release in_ready=1, and the next vector (all 4'b0010) streams a single clean beat with wl_bit=1 and wl_last=1.
